// File: rtl/reg_pkg.sv
// Register-file sizing shared by rename, RAT/RRAT and FRL.
package reg_pkg;
  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
endpackage

// File: rtl/rob_pkg.sv
// Backend recovery types shared by the ROB commit path and recovery logic.
package rob_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_DRAIN,
    ST_COPY,
    ST_FRL,
    ST_REDIRECT
  } recovery_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
  } recovery_redirect_t;

  function automatic logic [63:0] branch_target(
    input logic [63:0] pc,
    input logic [18:0] off
  );
    return pc + {{43{off[18]}}, off, 2'b00};
  endfunction
endpackage

// File: rtl/rat_restore_walker.sv
// Walks the RRAT in COPY_WIDTH-wide chunks and drives matching RAT writes.
module rat_restore_walker #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int COPY_WIDTH    = 4,
  parameter int AIDX_W        = 5,
  parameter int PIDX_W        = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         active_i,
  output logic                         last_chunk_o,
  output logic [COPY_WIDTH*AIDX_W-1:0] rd_idx_o,
  input  logic [COPY_WIDTH*PIDX_W-1:0] rd_data_i,
  output logic [COPY_WIDTH-1:0]        wr_en_o,
  output logic [COPY_WIDTH*AIDX_W-1:0] wr_idx_o,
  output logic [COPY_WIDTH*PIDX_W-1:0] wr_data_o
);
  localparam int NUM_CHUNKS =
    (NUM_ARCH_REGS + COPY_WIDTH - 1) / COPY_WIDTH;
  localparam int CNT_W =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  logic [CNT_W-1:0] chunk_q, chunk_d;
  int               lane;

  assign last_chunk_o = (int'(chunk_q) == NUM_CHUNKS - 1);

  always_comb begin
    chunk_d = chunk_q;
    if (start_i) begin
      chunk_d = '0;
    end else if (active_i) begin
      chunk_d = last_chunk_o ? '0 : chunk_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chunk_q <= '0;
    end else begin
      chunk_q <= chunk_d;
    end
  end

  // Lanes past the last register stay fully quiet, index included.
  always_comb begin
    rd_idx_o  = '0;
    wr_en_o   = '0;
    wr_idx_o  = '0;
    wr_data_o = '0;
    lane      = 0;
    for (int i = 0; i < COPY_WIDTH; i++) begin
      lane = int'(chunk_q) * COPY_WIDTH + i;
      if (active_i && lane < NUM_ARCH_REGS) begin
        wr_en_o[i] = 1'b1;
        rd_idx_o[i*AIDX_W +: AIDX_W] = AIDX_W'(lane);
        wr_idx_o[i*AIDX_W +: AIDX_W] = AIDX_W'(lane);
        wr_data_o[i*PIDX_W +: PIDX_W] =
          rd_data_i[i*PIDX_W +: PIDX_W];
      end
    end
  end
endmodule

// File: rtl/recovery_ctrl.sv
// Mispredict recovery: flush, drain, RAT restore, FRL rebuild, redirect.
module recovery_ctrl
  import rob_pkg::*;
#(
  parameter int NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
  parameter int COPY_WIDTH    = 4,
  parameter int AIDX_W        = $clog2(NUM_ARCH_REGS),
  parameter int PIDX_W        = $clog2(reg_pkg::NUM_PHYS_REGS)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         mispredict_commit_in,
  input  logic [63:0]                  mispredict_pc_in,
  input  logic [18:0]                  mispredict_offset_in,
  input  logic [3:0]                   fu_busy_in,
  output logic                         flush_out,
  output logic                         frontend_stall_out,
  output logic [COPY_WIDTH*AIDX_W-1:0] rrat_rd_idx_out,
  input  logic [COPY_WIDTH*PIDX_W-1:0] rrat_rd_data_in,
  output logic [COPY_WIDTH-1:0]        rat_wr_en_out,
  output logic [COPY_WIDTH*AIDX_W-1:0] rat_wr_idx_out,
  output logic [COPY_WIDTH*PIDX_W-1:0] rat_wr_data_out,
  output logic                         frl_rebuild_start_out,
  input  logic                         frl_rebuild_done_in,
  output logic                         redirect_valid_out,
  output logic [63:0]                  redirect_pc_out,
  output logic                         busy_out
);
  recovery_state_t    state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic               frl_seen_q, frl_seen_d;
  logic               walk_start;
  logic               walk_active;
  logic               last_chunk;
  recovery_redirect_t redir;

  assign walk_start  = (state_q == ST_DRAIN) && (fu_busy_in == '0);
  assign walk_active = (state_q == ST_COPY);

  rat_restore_walker #(
    .NUM_ARCH_REGS (NUM_ARCH_REGS),
    .COPY_WIDTH    (COPY_WIDTH),
    .AIDX_W        (AIDX_W),
    .PIDX_W        (PIDX_W)
  ) u_walker (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .start_i      (walk_start),
    .active_i     (walk_active),
    .last_chunk_o (last_chunk),
    .rd_idx_o     (rrat_rd_idx_out),
    .rd_data_i    (rrat_rd_data_in),
    .wr_en_o      (rat_wr_en_out),
    .wr_idx_o     (rat_wr_idx_out),
    .wr_data_o    (rat_wr_data_out)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (mispredict_commit_in) state_d = ST_FLUSH;
      ST_FLUSH:
        state_d = ST_DRAIN;
      ST_DRAIN:
        if (fu_busy_in == '0) state_d = ST_COPY;
      ST_COPY:
        if (last_chunk) state_d = ST_FRL;
      ST_FRL:
        if (frl_rebuild_done_in) state_d = ST_REDIRECT;
      ST_REDIRECT:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Target is captured only in IDLE; later commits are younger and squashed.
  always_comb begin
    pc_d = pc_q;
    if (state_q == ST_IDLE && mispredict_commit_in) begin
      pc_d = branch_target(mispredict_pc_in, mispredict_offset_in);
    end
    frl_seen_d = (state_q == ST_FRL);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_q       <= '0;
      frl_seen_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      frl_seen_q <= frl_seen_d;
    end
  end

  always_comb begin
    redir                 = '0;
    flush_out             = 1'b0;
    frl_rebuild_start_out = 1'b0;
    busy_out              = (state_q != ST_IDLE);
    frontend_stall_out    = busy_out;
    unique case (state_q)
      ST_FLUSH:    flush_out = 1'b1;
      ST_FRL:      frl_rebuild_start_out = !frl_seen_q;
      ST_REDIRECT: begin
        redir.valid = 1'b1;
        redir.pc    = pc_q;
      end
      default: ;
    endcase
    redirect_valid_out = redir.valid;
    redirect_pc_out    = redir.pc;
  end
endmodule

// File: tb/tb_recovery_ctrl.sv
// Directed bench for recovery_ctrl: default 32/4 instance plus a 33/4
// instance for the partial final chunk.
module tb_recovery_ctrl;
  localparam int W   = 4;
  localparam int AW  = 5;
  localparam int AW2 = 6;
  localparam int PW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mp, b_mp;
  logic [63:0]   mpc;
  logic [18:0]   moff;
  logic [3:0]    fbusy;
  logic          done;

  logic          flush, stall, frl_start, rv, bsy;
  logic [63:0]   rpc;
  logic [W*AW-1:0] rd_idx, wr_idx;
  logic [W*PW-1:0] rd_dat, wr_dat;
  logic [W-1:0]    wr_en;

  logic          b_flush, b_stall, b_frl_start, b_rv, b_bsy;
  logic [63:0]   b_rpc;
  logic [W*AW2-1:0] b_rd_idx, b_wr_idx;
  logic [W*PW-1:0]  b_rd_dat, b_wr_dat;
  logic [W-1:0]     b_wr_en;

  int n_checks = 0;
  int n_fail   = 0;
  int red_cnt  = 0;

  function automatic logic [5:0] rrat_map(input int k);
    return 6'((k * 5 + 3) % 64);
  endfunction

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < W; i++)
      rd_dat[i*PW +: PW] = rrat_map(int'(rd_idx[i*AW +: AW]));
  end

  always_comb begin
    b_rd_dat = '0;
    for (int i = 0; i < W; i++)
      b_rd_dat[i*PW +: PW] = rrat_map(int'(b_rd_idx[i*AW2 +: AW2]));
  end

  always @(negedge clk) if (rv) red_cnt++;

  recovery_ctrl dut (
    .clk_in                (clk),
    .rst_in                (rst),
    .mispredict_commit_in  (mp),
    .mispredict_pc_in      (mpc),
    .mispredict_offset_in  (moff),
    .fu_busy_in            (fbusy),
    .flush_out             (flush),
    .frontend_stall_out    (stall),
    .rrat_rd_idx_out       (rd_idx),
    .rrat_rd_data_in       (rd_dat),
    .rat_wr_en_out         (wr_en),
    .rat_wr_idx_out        (wr_idx),
    .rat_wr_data_out       (wr_dat),
    .frl_rebuild_start_out (frl_start),
    .frl_rebuild_done_in   (done),
    .redirect_valid_out    (rv),
    .redirect_pc_out       (rpc),
    .busy_out              (bsy)
  );

  recovery_ctrl #(.NUM_ARCH_REGS(33)) dut33 (
    .clk_in                (clk),
    .rst_in                (rst),
    .mispredict_commit_in  (b_mp),
    .mispredict_pc_in      (mpc),
    .mispredict_offset_in  (moff),
    .fu_busy_in            (fbusy),
    .flush_out             (b_flush),
    .frontend_stall_out    (b_stall),
    .rrat_rd_idx_out       (b_rd_idx),
    .rrat_rd_data_in       (b_rd_dat),
    .rat_wr_en_out         (b_wr_en),
    .rat_wr_idx_out        (b_wr_idx),
    .rat_wr_data_out       (b_wr_dat),
    .frl_rebuild_start_out (b_frl_start),
    .frl_rebuild_done_in   (done),
    .redirect_valid_out    (b_rv),
    .redirect_pc_out       (b_rpc),
    .busy_out              (b_bsy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_flush"}, 64'(flush), 0);
    chk({tag, "_stall"}, 64'(stall), 0);
    chk({tag, "_busy"}, 64'(bsy), 0);
    chk({tag, "_wen"}, 64'(wr_en), 0);
    chk({tag, "_widx"}, 64'(wr_idx), 0);
    chk({tag, "_ridx"}, 64'(rd_idx), 0);
    chk({tag, "_wdat"}, 64'(wr_dat), 0);
    chk({tag, "_frl"}, 64'(frl_start), 0);
    chk({tag, "_rv"}, 64'(rv), 0);
    chk({tag, "_rpc"}, rpc, 0);
  endtask

  task automatic recover(input logic [63:0] pc, input logic [18:0] off,
                         input logic [63:0] exp_pc, input int drain_n,
                         input int frl_n, input bit repulse);
    logic [W-1:0]    e_en;
    logic [W*AW-1:0] e_idx;
    logic [W*PW-1:0] e_dat;
    int r0;
    int k;
    r0    = red_cnt;
    mp    = 1'b1;
    mpc   = pc;
    moff  = off;
    fbusy = (drain_n > 0) ? 4'b0100 : 4'b0000;
    done  = (frl_n == 0);
    step();
    mp = 1'b0;
    chk("flush_t1", 64'(flush), 1);
    chk("stall_t1", 64'(stall), 1);
    step();
    chk("flush_t2", 64'(flush), 0);
    chk("wen_drain", 64'(wr_en), 0);
    for (int d = 1; d <= drain_n; d++) begin
      step();
      chk("wen_drain_wait", 64'(wr_en), 0);
      chk("busy_drain_wait", 64'(bsy), 1);
    end
    fbusy = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      step();
      e_en = '0; e_idx = '0; e_dat = '0;
      for (int i = 0; i < W; i++) begin
        k = c * W + i;
        e_en[i] = 1'b1;
        e_idx[i*AW +: AW] = AW'(k);
        e_dat[i*PW +: PW] = rrat_map(k);
      end
      chk("copy_wen", 64'(wr_en), 64'(e_en));
      chk("copy_widx", 64'(wr_idx), 64'(e_idx));
      chk("copy_ridx", 64'(rd_idx), 64'(e_idx));
      chk("copy_wdat", 64'(wr_dat), 64'(e_dat));
      if (repulse && c == 1) begin
        mp  = 1'b1;
        mpc = 64'hDEAD_0000;
      end
      if (c == 2) mp = 1'b0;
    end
    step();
    chk("frl_start", 64'(frl_start), 1);
    chk("frl_wen", 64'(wr_en), 0);
    for (int f = 0; f < frl_n; f++) begin
      step();
      chk("frl_wait_start", 64'(frl_start), 0);
      chk("frl_wait_rv", 64'(rv), 0);
      chk("frl_wait_stall", 64'(stall), 1);
    end
    done = 1'b1;
    step();
    chk("redir_valid", 64'(rv), 1);
    chk("redir_pc", rpc, exp_pc);
    step();
    chk("end_stall", 64'(stall), 0);
    chk("end_rv", 64'(rv), 0);
    chk("redir_count", 64'(red_cnt - r0), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0]     e_en;
    logic [W*AW2-1:0] e_idx;
    logic [W*PW-1:0]  e_dat;
    int k;
    int r0;
    rst = 1'b1; mp = 1'b0; b_mp = 1'b0;
    mpc = '0; moff = '0; fbusy = '0; done = 1'b1;
    step(); step(); step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    recover(64'h1000, 19'd4, 64'h1010, 0, 0, 1'b0);
    recover(64'h2000, 19'h7FFFF, 64'h1FFC, 0, 0, 1'b0);
    recover(64'h4000, 19'd8, 64'h4020, 5, 0, 1'b0);
    recover(64'h8000, 19'd1, 64'h8004, 0, 10, 1'b1);

    r0 = red_cnt;
    mp = 1'b1; mpc = 64'h5000; moff = 19'd2;
    step();
    mp = 1'b0;
    step();
    for (int c = 0; c < 4; c++) step();
    chk("mid_copy_wen", 64'(wr_en), 64'hF);
    rst = 1'b1;
    step();
    chk_idle("rst_copy");
    rst = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("rst_no_redir", 64'(red_cnt - r0), 0);
    chk("rst_stays_idle", 64'(bsy), 0);
    recover(64'h6000, 19'd3, 64'h600C, 0, 0, 1'b0);

    rst = 1'b1; mp = 1'b1; mpc = 64'h7000;
    step();
    rst = 1'b0; mp = 1'b0;
    chk("rst_wins_busy", 64'(bsy), 0);
    step();
    chk("rst_wins_flush", 64'(flush), 0);

    b_mp = 1'b1; mpc = 64'h3000; moff = 19'd1;
    step();
    b_mp = 1'b0;
    chk("b_flush", 64'(b_flush), 1);
    step();
    for (int c = 0; c < 9; c++) begin
      step();
      e_en = '0; e_idx = '0; e_dat = '0;
      for (int i = 0; i < W; i++) begin
        k = c * W + i;
        if (k < 33) begin
          e_en[i] = 1'b1;
          e_idx[i*AW2 +: AW2] = AW2'(k);
          e_dat[i*PW +: PW] = rrat_map(k);
        end
      end
      chk("b_copy_wen", 64'(b_wr_en), 64'(e_en));
      chk("b_copy_widx", 64'(b_wr_idx), 64'(e_idx));
      chk("b_copy_wdat", 64'(b_wr_dat), 64'(e_dat));
      if (c == 8) begin
        chk("b_last_wen", 64'(b_wr_en), 64'h1);
        chk("b_last_idx0", 64'(b_wr_idx[AW2-1:0]), 32);
      end
    end
    step();
    chk("b_frl_start", 64'(b_frl_start), 1);
    step();
    chk("b_redir_valid", 64'(b_rv), 1);
    chk("b_redir_pc", b_rpc, 64'h3004);
    step();
    chk("b_end_busy", 64'(b_bsy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/recovery_ctrl.md
# recovery_ctrl

Branch-mispredict recovery sequencer for the out-of-order backend. When the ROB commits a branch marked `pc_incorrect`, it:

- flushes the ROB and all four functional units;
- holds the frontend stalled while the units drain;
- copies the committed RRAT mappings back into the speculative RAT in fixed-width chunks;
- triggers a free-register-list rebuild;
- issues one redirect to fetch.

It sits between the ROB commit path, the RAT/RRAT/FRL, and the branch predictor interface.

## Interface
Parameters:
- `NUM_ARCH_REGS`, 32: architectural integer registers to restore (NZCV included by the caller as an extra index if needed).
- `COPY_WIDTH`, 4: RAT entries restored per cycle.
- `AIDX_W`, `$clog2(NUM_ARCH_REGS)`: architectural index width.
- `PIDX_W`, `$clog2(reg_pkg::NUM_PHYS_REGS)`: physical index width.

Ports:
- `clk_in` in 1: the single clock.
- `rst_in` in 1: reset, synchronous and active-high.
- `mispredict_commit_in` in 1: ROB head is a committed mispredicted branch.
- `mispredict_pc_in` in 64: PC of that branch.
- `mispredict_offset_in` in 19: signed word offset to the correct target.
- `fu_busy_in` in 4: busy flags {bru, lsu, fpu, alu}.
- `flush_out` out 1: squash pulse to ROB and FUs.
- `frontend_stall_out` out 1: blocks RAT/queue intake.
- `rrat_rd_idx_out` out `COPY_WIDTH*AIDX_W`: RRAT read indices (combinational read).
- `rrat_rd_data_in` in `COPY_WIDTH*PIDX_W`: RRAT mappings, valid the same cycle.
- `rat_wr_en_out` out `COPY_WIDTH`: per-lane RAT write enables.
- `rat_wr_idx_out` out `COPY_WIDTH*AIDX_W`: RAT write indices.
- `rat_wr_data_out` out `COPY_WIDTH*PIDX_W`: physical regs to write.
- `frl_rebuild_start_out` out 1: one-cycle start pulse to the FRL.
- `frl_rebuild_done_in` in 1: FRL rebuild complete.
- `redirect_valid_out` out 1: one-cycle fetch redirect.
- `redirect_pc_out` out 64: corrected PC.
- `busy_out` out 1: FSM not in IDLE.

## Operation
FSM states: IDLE, FLUSH, DRAIN, COPY, FRL, REDIRECT.
- **IDLE:** waits for `mispredict_commit_in`.
  - On it, latches `redirect_pc = mispredict_pc_in + {sext(mispredict_offset_in), 2'b00}` as a 64-bit add with wrap-around.
  - Then goes to FLUSH.
- **FLUSH:** `flush_out`=1 for exactly one cycle, then DRAIN.
- **DRAIN:** stays while `fu_busy_in != 0`. When all flags are 0 it clears the chunk counter and goes to COPY.
- **COPY:**
  - Lane i reads and writes index `base+i`, where `base = chunk*COPY_WIDTH`.
  - `rat_wr_data_out` lane i equals `rrat_rd_data_in` lane i in the same cycle.
  - Lanes with `base+i >= NUM_ARCH_REGS` have write enable 0.
  - Runs for `ceil(NUM_ARCH_REGS/COPY_WIDTH)` cycles, then goes to FRL.
- **FRL:** `frl_rebuild_start_out`=1 on the entry cycle only. Stays until `frl_rebuild_done_in`=1 is sampled, then goes to REDIRECT.
- **REDIRECT:** `redirect_valid_out`=1 with the latched PC for one cycle, then IDLE.
- `frontend_stall_out` = `busy_out` = (state != IDLE).
- `mispredict_commit_in` outside IDLE is ignored: younger branches are already squashed.

## Timing
- Reset value of every output is 0, including `redirect_pc_out` and all index/data buses. The state resets to IDLE and the chunk counter to 0.
- `rst_in` asserted in any state returns to IDLE the next cycle with no redirect issued. Reset wins over a simultaneous `mispredict_commit_in`.
- Cycle-by-cycle, with mispredict sampled at cycle t and defaults (32/4), no drain wait, and done returned immediately:

| Cycle | State | Outputs |
|---|---|---|
| t+1 | FLUSH | flush, stall=1 |
| t+2 | DRAIN | |
| t+3 … t+10 | COPY | 8 cycles |
| t+11 | FRL | start |
| t+12 | REDIRECT | redirect |
| t+13 | IDLE | stall=0 |

- Minimum recovery latency is therefore 12 cycles from the sampled mispredict to redirect.
- `frl_rebuild_done_in` is ignored outside FRL.
- `frl_rebuild_done_in` asserted on the FRL entry cycle is accepted.
- Index/data/enable buses are 0 outside COPY.

## Structure
- `typedef enum logic [2:0] recovery_state_t` and a `recovery_redirect_t` struct {valid, pc} go in `rob_pkg`.
- `NUM_ARCH_REGS` is taken from `reg_pkg`.
- One sub-module is natural: `rat_restore_walker`. It holds the chunk counter and the lane index/enable generation, exposing `start` / `last_chunk` to the FSM.

## Test plan
- **Basic recovery:** mispredict with pc=0x1000 and offset=+4 (defaults, FUs idle, done at FRL entry) -> `flush_out` at t+1, RAT writes at indices 0..31 over t+3..t+10 matching RRAT data, `frl_rebuild_start_out` at t+11, `redirect_valid_out` at t+12 with pc 0x1010, stall low at t+13.
- **Negative offset:** pc=0x2000, offset=19'h7FFFF (−1) -> `redirect_pc_out`=0x1FFC.
- **Drain stall:** `fu_busy_in`=4'b0100 held for 5 cycles after FLUSH -> COPY begins exactly 1 cycle after busy clears; no RAT writes earlier.
- **Partial chunk:** `NUM_ARCH_REGS`=33, `COPY_WIDTH`=4 -> 9 COPY cycles; last cycle `rat_wr_en_out`=4'b0001 with index 32.
- **Slow FRL and repeated mispredict:** done delayed 10 cycles, with a second `mispredict_commit_in` pulsed during COPY -> exactly one redirect, carrying the first PC.
- **Reset mid-COPY:** `rst_in` at the 4th COPY cycle -> next cycle all outputs 0, state IDLE, no redirect; a fresh mispredict afterwards completes normally.
